// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss/fill controller: serves cache lookups for three fetch ports,
// issues one line request to memory per miss, and writes the returned line into the cache.
module icache_fill_ctrl #(
   parameter int MEM_TAG_W = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [2:0][31:0]     fetch_pc,
   input  logic [2:0]           fetch_valid,
   input  logic                 squash,
   input  logic                 mem_busy,
   input  logic [MEM_TAG_W-1:0] mem2proc_response,
   input  logic [63:0]          mem2proc_data,
   input  logic [MEM_TAG_W-1:0] mem2proc_tag,
   input  logic [2:0][63:0]     cm_data,
   input  logic [2:0]           cm_valid,
   output logic [2:0][4:0]      cm_rd_index,
   output logic [2:0][7:0]      cm_rd_tag,
   output logic                 cm_wr_en,
   output logic [4:0]           cm_wr_index,
   output logic [7:0]           cm_wr_tag,
   output logic [63:0]          cm_wr_data,
   output logic [1:0]           proc2mem_command,
   output logic [31:0]          proc2mem_addr,
   output logic [2:0][63:0]     inst_data,
   output logic [2:0]           inst_valid,
   output logic                 miss_busy,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] CMD_NONE = 2'h0;
   localparam logic [1:0] CMD_LOAD = 2'h1;

   state_t               r_state;
   logic [MEM_TAG_W-1:0] r_pending_tag;
   logic [4:0]           r_miss_index;
   logic [7:0]           r_miss_tag;
   logic [31:0]          r_miss_addr;

   logic [2:0]  w_miss;
   logic        w_any_miss;
   logic [31:0] w_sel_pc;
   logic        w_load;
   logic        w_accept;
   logic        w_fill;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cm_rd_index[i] = fetch_pc[i][7:3];
         cm_rd_tag[i]   = fetch_pc[i][15:8];
      end
   end

   assign inst_data  = cm_data;
   assign inst_valid = fetch_valid & cm_valid;

   // Port 2 is the oldest fetch, so it wins when several ports miss together.
   assign w_miss     = fetch_valid & ~cm_valid;
   assign w_any_miss = |w_miss;

   always_comb begin
      w_sel_pc = fetch_pc[0];
      if (w_miss[2]) begin
         w_sel_pc = fetch_pc[2];
      end else if (w_miss[1]) begin
         w_sel_pc = fetch_pc[1];
      end
   end

   assign w_load   = (r_state == S_REQ) && !mem_busy;
   assign w_accept = w_load && (mem2proc_response != '0);
   assign w_fill   = (r_state == S_WAIT) && (mem2proc_tag != '0) &&
                     (mem2proc_tag == r_pending_tag);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pending_tag <= '0;
         r_miss_index  <= '0;
         r_miss_tag    <= '0;
         r_miss_addr   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_miss && !squash) begin
                  r_miss_index <= w_sel_pc[7:3];
                  r_miss_tag   <= w_sel_pc[15:8];
                  r_miss_addr  <= w_sel_pc & 32'hFFFF_FFF8;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               // Acceptance beats a same-cycle squash: memory already owns the request.
               if (w_accept) begin
                  r_pending_tag <= mem2proc_response;
                  r_state       <= S_WAIT;
               end else if (squash) begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (w_fill) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign proc2mem_command = w_load ? CMD_LOAD : CMD_NONE;
   assign proc2mem_addr    = w_load ? r_miss_addr : 32'h0;
   assign cm_wr_en         = w_fill;
   assign cm_wr_index      = r_miss_index;
   assign cm_wr_tag        = r_miss_tag;
   assign cm_wr_data       = mem2proc_data;
   assign miss_busy        = (r_state != S_IDLE);
   assign dbg_state        = r_state;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a transaction-level model.
module tb_icache_fill_ctrl;

   localparam int TW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0][31:0]  fetch_pc;
   logic [2:0]        fetch_valid;
   logic              squash;
   logic              mem_busy;
   logic [TW-1:0]     mem2proc_response;
   logic [63:0]       mem2proc_data;
   logic [TW-1:0]     mem2proc_tag;
   logic [2:0][63:0]  cm_data;
   logic [2:0]        cm_valid;
   logic [2:0][4:0]   cm_rd_index;
   logic [2:0][7:0]   cm_rd_tag;
   logic              cm_wr_en;
   logic [4:0]        cm_wr_index;
   logic [7:0]        cm_wr_tag;
   logic [63:0]       cm_wr_data;
   logic [1:0]        proc2mem_command;
   logic [31:0]       proc2mem_addr;
   logic [2:0][63:0]  inst_data;
   logic [2:0]        inst_valid;
   logic              miss_busy;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Model: a miss is either waiting for memory to take it, or taken and waiting for data.
   bit        m_have_miss = 0;
   bit        m_accepted  = 0;
   int        m_ptag      = 0;
   bit [31:0] m_addr      = 0;
   int        m_idx       = 0;
   int        m_tg        = 0;

   icache_fill_ctrl #(.MEM_TAG_W(TW)) dut (
      .clock(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
      .squash(squash), .mem_busy(mem_busy), .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag), .cm_data(cm_data),
      .cm_valid(cm_valid), .cm_rd_index(cm_rd_index), .cm_rd_tag(cm_rd_tag),
      .cm_wr_en(cm_wr_en), .cm_wr_index(cm_wr_index), .cm_wr_tag(cm_wr_tag),
      .cm_wr_data(cm_wr_data), .proc2mem_command(proc2mem_command),
      .proc2mem_addr(proc2mem_addr), .inst_data(inst_data), .inst_valid(inst_valid),
      .miss_busy(miss_busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_fill();
      return m_accepted && (mem2proc_tag != 0) && (int'(mem2proc_tag) == m_ptag);
   endfunction

   task automatic model_compare();
      bit exp_load;
      bit exp_fill;
      for (int i = 0; i < 3; i++) begin
         check("rd_index", 64'(cm_rd_index[i]), 64'((fetch_pc[i] / 8) % 32));
         check("rd_tag", 64'(cm_rd_tag[i]), 64'((fetch_pc[i] / 256) % 256));
         check("inst_data", inst_data[i], cm_data[i]);
      end
      check("inst_valid", 64'(inst_valid), 64'(fetch_valid & cm_valid));
      exp_load = m_have_miss && !m_accepted && !mem_busy;
      exp_fill = model_fill();
      check("command", 64'(proc2mem_command), exp_load ? 64'd1 : 64'd0);
      check("addr", 64'(proc2mem_addr), exp_load ? 64'(m_addr) : 64'd0);
      check("miss_busy", 64'(miss_busy), 64'(m_have_miss));
      check("wr_en", 64'(cm_wr_en), 64'(exp_fill));
      if (exp_fill) begin
         check("wr_index", 64'(cm_wr_index), 64'(m_idx));
         check("wr_tag", 64'(cm_wr_tag), 64'(m_tg));
         check("wr_data", cm_wr_data, mem2proc_data);
      end
   endtask

   task automatic model_update();
      bit fill;
      int sel;
      fill = model_fill();
      if (reset) begin
         m_have_miss = 0; m_accepted = 0; m_ptag = 0; m_addr = 0; m_idx = 0; m_tg = 0;
      end else if (!m_have_miss) begin
         sel = -1;
         for (int i = 0; i < 3; i++)
            if (fetch_valid[i] && !cm_valid[i]) sel = i;
         if (sel >= 0 && !squash) begin
            m_have_miss = 1;
            m_addr = fetch_pc[sel] - (fetch_pc[sel] % 8);
            m_idx  = int'((fetch_pc[sel] / 8) % 32);
            m_tg   = int'((fetch_pc[sel] / 256) % 256);
         end
      end else if (!m_accepted) begin
         if (!mem_busy && mem2proc_response != 0) begin
            m_accepted = 1;
            m_ptag = int'(mem2proc_response);
         end else if (squash) begin
            m_have_miss = 0;
         end
      end else if (fill) begin
         m_have_miss = 0;
         m_accepted = 0;
      end
   endtask

   task automatic settle();
      #1;
      model_compare();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic quiet();
      fetch_valid = 3'b000; cm_valid = 3'b111; squash = 0; mem_busy = 0;
      mem2proc_response = '0; mem2proc_tag = '0;
   endtask

   task automatic make_miss(input logic [31:0] pc);
      fetch_pc[0] = pc; fetch_valid = 3'b001; cm_valid = 3'b110;
      settle(); tick();
      quiet();
   endtask

   initial begin
      reset = 1; quiet();
      fetch_pc = '0; mem2proc_data = '0; cm_data = '0;
      @(negedge clk);
      tick(); tick();
      reset = 0;
      settle();
      check("reset_busy", 64'(miss_busy), 64'd0);
      check("reset_cmd", 64'(proc2mem_command), 64'd0);
      check("reset_addr", 64'(proc2mem_addr), 64'd0);
      check("reset_wr_en", 64'(cm_wr_en), 64'd0);
      tick();

      // All ports hit.
      fetch_pc[0] = 32'h0000_0100; fetch_pc[1] = 32'h0000_2208; fetch_pc[2] = 32'h0000_3310;
      cm_data[0] = 64'hA0; cm_data[1] = 64'hA1; cm_data[2] = 64'hA2;
      fetch_valid = 3'b111; cm_valid = 3'b111;
      settle();
      check("hit_valid", 64'(inst_valid), 64'h7);
      check("hit_cmd", 64'(proc2mem_command), 64'd0);
      tick(); settle();
      check("hit_idle", 64'(miss_busy), 64'd0);

      // Port 1 misses at 0x1238.
      fetch_pc[1] = 32'h0000_1238; cm_valid = 3'b101;
      settle(); tick();
      quiet(); mem2proc_response = 4'd3;
      settle();
      check("miss_cmd", 64'(proc2mem_command), 64'd1);
      check("miss_addr", 64'(proc2mem_addr), 64'h1238);
      check("miss_busy", 64'(miss_busy), 64'd1);
      tick();
      quiet(); mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0123_4567;
      settle();
      check("fill_en", 64'(cm_wr_en), 64'd1);
      check("fill_index", 64'(cm_wr_index), 64'd7);
      check("fill_tag", 64'(cm_wr_tag), 64'h12);
      check("fill_data", cm_wr_data, 64'hDEAD_BEEF_0123_4567);
      tick();
      quiet(); settle();
      check("fill_idle", 64'(miss_busy), 64'd0);
      tick();

      // Ports 2 and 0 miss; memory rejects twice, is busy once, then takes tag 5.
      fetch_pc[2] = 32'h0000_ABCD; fetch_pc[0] = 32'h0000_4440;
      fetch_valid = 3'b111; cm_valid = 3'b010;
      settle(); tick();
      quiet();
      for (int k = 0; k < 2; k++) begin
         settle();
         check("retry_load", 64'(proc2mem_command), 64'd1);
         check("prio_addr", 64'(proc2mem_addr), 64'hABC8);
         tick();
      end
      mem_busy = 1; mem2proc_response = 4'd5;
      settle();
      check("busy_none", 64'(proc2mem_command), 64'd0);
      tick();
      mem_busy = 0;
      settle();
      check("retry_accept_load", 64'(proc2mem_command), 64'd1);
      tick();
      quiet(); mem2proc_tag = 4'd4; mem2proc_data = 64'h1111;
      settle();
      check("wrong_tag_no_fill", 64'(cm_wr_en), 64'd0);
      tick();
      mem2proc_tag = 4'd5; mem2proc_data = 64'h5555;
      settle();
      check("retry_fill", 64'(cm_wr_en), 64'd1);
      tick();

      // Squash before acceptance abandons the miss.
      quiet();
      make_miss(32'h0000_0100);
      squash = 1;
      settle(); tick();
      quiet(); mem2proc_tag = 4'd5;
      settle();
      check("squash_idle", 64'(miss_busy), 64'd0);
      check("squash_no_fill", 64'(cm_wr_en), 64'd0);
      tick();

      // Acceptance in the squash cycle wins, and squash in WAIT does not stop the fill.
      quiet();
      make_miss(32'h0000_0208);
      squash = 1; mem2proc_response = 4'd6;
      settle(); tick();
      quiet(); squash = 1;
      settle();
      check("squash_accept_wait", 64'(miss_busy), 64'd1);
      tick();
      mem2proc_tag = 4'd6; mem2proc_data = 64'h6666;
      settle();
      check("squash_wait_fill", 64'(cm_wr_en), 64'd1);
      check("squash_wait_index", 64'(cm_wr_index), 64'd1);
      tick();

      // Reset while waiting on tag 2 discards the fill.
      quiet();
      make_miss(32'h0000_0310);
      mem2proc_response = 4'd2;
      settle(); tick();
      quiet(); reset = 1;
      settle(); tick();
      reset = 0; mem2proc_tag = 4'd2;
      settle();
      check("reset_wait_no_fill", 64'(cm_wr_en), 64'd0);
      check("reset_wait_idle", 64'(miss_busy), 64'd0);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            fetch_pc[i] = $urandom;
            cm_data[i]  = {$urandom, $urandom};
            cm_valid[i] = ($urandom_range(0, 2) != 0);
         end
         fetch_valid = 3'($urandom_range(0, 7));
         squash      = ($urandom_range(0, 9) == 0);
         mem_busy    = ($urandom_range(0, 3) == 0);
         mem2proc_response = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom_range(1, 15));
         mem2proc_data = {$urandom, $urandom};
         mem2proc_tag  = ($urandom_range(0, 2) == 0) ? TW'(m_ptag) : TW'($urandom_range(0, 15));
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 Parameter MEM_TAG_W, default 4: width of memory transaction tag.
REQ-002 clock  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_pc  input  [2:0][31:0]  fetch addresses; port 2 oldest, highest priority.
REQ-005 fetch_valid  input  [2:0]  per-port fetch request valid.
REQ-006 squash  input  1  front-end redirect; abandons a miss not yet accepted by memory.
REQ-007 mem_busy  input  1  memory port owned by another requester this cycle.
REQ-008 mem2proc_response  input  MEM_TAG_W  nonzero = request accepted with this tag; zero = rejected.
REQ-009 mem2proc_data  input  64  returned line data.
REQ-010 mem2proc_tag  input  MEM_TAG_W  tag of returning data; zero = no data.
REQ-011 cm_data / cm_valid  input  [2:0][63:0] / [2:0]  lookup results from the cache memory.
REQ-012 cm_rd_index / cm_rd_tag  output  [2:0][4:0] / [2:0][7:0]  lookup index = fetch_pc[i][7:3], tag = fetch_pc[i][15:8], combinational.
REQ-013 cm_wr_en, cm_wr_index[4:0], cm_wr_tag[7:0], cm_wr_data[63:0]  output  fill write to the cache memory.
REQ-014 proc2mem_command  output  2  2'h0 NONE, 2'h1 LOAD.
REQ-015 proc2mem_addr  output  32  line address, low 3 bits zero.
REQ-016 inst_data / inst_valid  output  [2:0][63:0] / [2:0]  data = cm_data; valid = fetch_valid & cm_valid.
REQ-017 miss_busy  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states IDLE, REQ, WAIT; fill written from WAIT, no separate fill state.
REQ-019 IDLE: if any port has fetch_valid=1 and cm_valid=0 and squash=0, latch index/tag/line address of the highest-numbered such port and enter REQ next cycle; else stay.
REQ-020 REQ: proc2mem_command=LOAD, proc2mem_addr={miss_pc[31:3],3'b000} when mem_busy=0; command=NONE when mem_busy=1.
REQ-021 REQ with command LOAD and mem2proc_response!=0: capture response into pending_tag, enter WAIT.
REQ-022 REQ with response zero or mem_busy=1: remain in REQ, reissue next cycle, no limit on retries.
REQ-023 REQ with squash=1 and no acceptance that cycle: return to IDLE; acceptance in the same cycle as squash takes precedence (enter WAIT).
REQ-024 WAIT: when mem2proc_tag==pending_tag and mem2proc_tag!=0, assert cm_wr_en for exactly that cycle with latched index/tag and mem2proc_data, return to IDLE.
REQ-025 WAIT ignores squash; an accepted request always fills.
REQ-026 WAIT ignores returning data with non-matching tags.
REQ-027 At most one outstanding memory request; no new miss latched outside IDLE.
REQ-028 A filled line appears as a hit no earlier than the cycle after cm_wr_en.
REQ-029 Miss latched in IDLE the cycle after fill completes may re-request a just-filled line only if cm_valid is still 0; no suppression logic required.
REQ-030 cm_wr_en, proc2mem_command are 0/NONE in every state other than stated above.

Reset
REQ-031 reset=1 at posedge: state IDLE, pending_tag 0, latched index/tag/address 0; cm_wr_en=0, proc2mem_command=NONE, proc2mem_addr=0, miss_busy=0 from the following cycle.
REQ-032 reset overrides all other inputs, including reset in WAIT: pending fill discarded, later matching tag ignored.

Verification
REQ-033 Hit: fetch_valid=3'b111, cm_valid=3'b111 -> inst_valid=3'b111, command NONE, state IDLE.
REQ-034 Miss: port1 pc=0x0000_1238 misses, others hit -> REQ, addr 0x0000_1238, response 3 -> WAIT; tag 3 with data D -> cm_wr_en=1, index 7, tag 0x12, data D, IDLE next.
REQ-035 Priority: ports 2 and 0 miss -> port 2 address issued.
REQ-036 Retry: response 0 twice then 5, mem_busy high one cycle -> LOAD repeated, NONE during busy, accepted on tag 5.
REQ-037 Squash in REQ before acceptance -> IDLE, no fill; squash in WAIT -> fill still written on matching tag.
REQ-038 Reset in WAIT pending tag 2 -> IDLE; later mem2proc_tag=2 -> cm_wr_en stays 0.
